// File: rtl/id_decode_pipe.sv
// Pipelined instruction-decode stage: decodes, selects operands, resolves branches into an ID/EXE register.
// Optional macro ID_BRANCH_SQUASH_EN squashes the instruction after a taken branch (no delay slot).
module id_decode_pipe #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 32,
  parameter int FUNC_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instruction,
  input  logic [PC_W-1:0]   pc_in,
  input  logic [DATA_W-1:0] registerval1,
  input  logic [DATA_W-1:0] registerval2,
  input  logic              hazard_detected_in,
  input  logic              flush,
  input  logic              out_ready,
  output logic [4:0]        source1,
  output logic [4:0]        src2_reg_file,
  output logic              out_valid,
  output logic [FUNC_W-1:0] EXE_CMD,
  output logic [DATA_W-1:0] valuein1,
  output logic [DATA_W-1:0] valuein2,
  output logic [4:0]        src1_forw,
  output logic [4:0]        src2_forw,
  output logic [4:0]        dest,
  output logic              memory_read_enabled,
  output logic              memory_write_enabled,
  output logic              writeback_enabled,
  output logic [DATA_W-1:0] st_data,
  output logic              brTaken,
  output logic [PC_W-1:0]   br_target,
  output logic              illegal_op
);

  localparam logic [5:0] OP_NOP  = 6'd0;
  localparam logic [5:0] OP_ADDI = 6'd32;
  localparam logic [5:0] OP_LD   = 6'd36;
  localparam logic [5:0] OP_ST   = 6'd37;
  localparam logic [5:0] OP_BEZ  = 6'd40;
  localparam logic [5:0] OP_BNE  = 6'd41;
  localparam logic [5:0] OP_JMP  = 6'd42;

  logic [5:0]         op;
  logic signed [15:0] imm_s;
  logic signed [17:0] offset;
  logic [FUNC_W-1:0]  d_cmd;
  logic               d_is_imm, d_mr, d_mw, d_wb, d_taken, d_illegal, d_rd_src2;
  logic [DATA_W-1:0]  d_val2;
  logic [4:0]         d_src2_forw;
  logic [PC_W-1:0]    d_target;
  logic               slot_free, accept, load, squash;

  assign op       = instruction[31:26];
  assign imm_s    = $signed(instruction[15:0]);
  assign offset   = {imm_s, 2'b00};
  assign d_target = pc_in + PC_W'(offset);

  // NOTE: every decode output is defaulted before the case so no latch is inferred.
  always_comb begin
    d_cmd     = '0;
    d_is_imm  = 1'b0;
    d_mr      = 1'b0;
    d_mw      = 1'b0;
    d_wb      = 1'b0;
    d_taken   = 1'b0;
    d_illegal = 1'b0;
    d_rd_src2 = 1'b0;
    case (op) inside
      OP_NOP: ;
      [6'd1:6'd15]: begin d_cmd = FUNC_W'(op[3:0]); d_wb = 1'b1; end
      OP_ADDI: begin d_cmd = FUNC_W'(1); d_is_imm = 1'b1; d_wb = 1'b1; end
      OP_LD:   begin d_cmd = FUNC_W'(1); d_is_imm = 1'b1; d_mr = 1'b1; d_wb = 1'b1; end
      OP_ST:   begin d_cmd = FUNC_W'(1); d_is_imm = 1'b1; d_mw = 1'b1; d_rd_src2 = 1'b1; end
      OP_BEZ:  begin d_taken = (registerval1 == '0); d_rd_src2 = 1'b1; end
      OP_BNE:  begin d_taken = (registerval1 != registerval2); d_rd_src2 = 1'b1; end
      OP_JMP:  d_taken = 1'b1;
      default: d_illegal = 1'b1;
    endcase
  end

  assign source1       = instruction[20:16];
  assign src2_reg_file = d_rd_src2 ? instruction[25:21] : instruction[15:11];
  assign d_src2_forw   = d_is_imm ? 5'd0 : src2_reg_file;
  assign d_val2        = d_is_imm ? DATA_W'(imm_s) : registerval2;

  assign slot_free = !out_valid || out_ready;
  assign in_ready  = slot_free && !hazard_detected_in && !flush;
  assign accept    = in_valid && in_ready;
  assign load      = accept && !squash;

`ifdef ID_BRANCH_SQUASH_EN
  typedef enum logic {RUN, SQUASH} state_t;
  state_t state, state_n;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= RUN;
    else       state <= state_n;
  end

  // The instruction behind a taken branch is consumed but never reaches EXE.
  always_comb begin
    state_n = state;
    if (flush) state_n = RUN;
    else begin
      case (state)
        RUN:     if (load && d_taken) state_n = SQUASH;
        SQUASH:  if (accept) state_n = RUN;
        default: state_n = RUN;
      endcase
    end
  end

  assign squash = (state == SQUASH);
`else
  assign squash = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid            <= 1'b0;
      EXE_CMD              <= '0;
      valuein1             <= '0;
      valuein2             <= '0;
      src1_forw            <= '0;
      src2_forw            <= '0;
      dest                 <= '0;
      memory_read_enabled  <= 1'b0;
      memory_write_enabled <= 1'b0;
      writeback_enabled    <= 1'b0;
      st_data              <= '0;
      brTaken              <= 1'b0;
      br_target            <= '0;
      illegal_op           <= 1'b0;
    end else if (load) begin
      out_valid            <= 1'b1;
      EXE_CMD              <= d_cmd;
      valuein1             <= registerval1;
      valuein2             <= d_val2;
      src1_forw            <= source1;
      src2_forw            <= d_src2_forw;
      dest                 <= instruction[25:21];
      memory_read_enabled  <= d_mr;
      memory_write_enabled <= d_mw;
      writeback_enabled    <= d_wb;
      st_data              <= registerval2;
      brTaken              <= d_taken;
      br_target            <= d_target;
      illegal_op           <= d_illegal;
    end else if (flush || slot_free) begin
      // Bubble: side-effecting controls are cleared along with out_valid.
      out_valid            <= 1'b0;
      memory_read_enabled  <= 1'b0;
      memory_write_enabled <= 1'b0;
      writeback_enabled    <= 1'b0;
      brTaken              <= 1'b0;
      illegal_op           <= 1'b0;
    end
  end

endmodule

// File: doc/id_decode_pipe.md
# id_decode_pipe

Parametrised, pipelined instruction-decode stage for the 5-stage core: decodes a 32-bit instruction, selects operands, evaluates branch conditions and registers everything into an ID/EXE pipeline register behind a valid/ready handshake. Supersedes the combinational decoder. Adds:
- configurable datapath width;
- back-pressure;
- hazard bubbles;
- flush;
- taken-branch squash.

Sits between IF/ID and EXE.

## Interface
Parameters:
- DATA_W, 32, register/operand width (≥16)
- PC_W, 32, program-counter width
- FUNC_W, 4, EXE_CMD width (≥4)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  instruction/pc_in/register values valid
- in_ready  out  1  stage accepts input this cycle
- instruction  in  32  instruction word
- pc_in  in  PC_W  address of the following instruction (PC+4)
- registerval1, registerval2  in  DATA_W  register-file read data for source1, src2_reg_file
- hazard_detected_in  in  1  load-use hazard; stall input, insert bubble
- flush  in  1  synchronous kill of the pipeline register
- out_ready  in  1  EXE accepts output
- source1, src2_reg_file  out  5  register-file read addresses (combinational)
- out_valid  out  1  registered outputs hold a real instruction
- EXE_CMD  out  FUNC_W  ALU command
- valuein1, valuein2  out  DATA_W  operands (valuein2 = sign-extended imm when is_imm)
- src1_forw, src2_forw, dest  out  5  forwarding sources, destination register
- memory_read_enabled, memory_write_enabled, writeback_enabled  out  1  control
- st_data  out  DATA_W  store data (registerval2)
- brTaken  out  1  registered branch-taken
- br_target  out  PC_W  branch/jump target
- illegal_op  out  1  registered undefined-opcode flag

## Operation
- Fields:
  - op = [31:26];
  - dest = [25:21];
  - source1 = [20:16];
  - src2_reg_file = [25:21] for ST/BNE/BEZ, else [15:11];
  - imm = [15:0], sign-extended to DATA_W.
- Opcodes:
  - 0 NOP: all enables 0.
  - 1–15 register ALU: EXE_CMD=op[3:0], writeback=1, src2_forw=[15:11].
  - 32 ADDI: EXE_CMD=1, is_imm, writeback.
  - 36 LD: EXE_CMD=1, is_imm, memory_read, writeback.
  - 37 ST: EXE_CMD=1, is_imm, memory_write.
  - 40 BEZ: taken if registerval1==0.
  - 41 BNE: taken if registerval1!=registerval2.
  - 42 JMP: always taken.
  - Any other opcode: NOP enables, illegal_op=1.
- For is_imm ops src2_forw=0. For branches/JMP all enables are 0 and EXE_CMD=0.
- br_target = pc_in + (sext(imm) << 2), truncated to PC_W. Defined for every instruction; meaningful only when brTaken=1.
- Register load condition: slot_free = !out_valid || out_ready.
- in_ready = slot_free && !hazard_detected_in && !flush.
- Priority each cycle:
  - flush: out_valid←0, state←RUN.
  - Otherwise, if slot_free and hazard_detected_in: out_valid←0 (bubble).
  - Otherwise, if in_valid&&in_ready: load the decoded instruction.
  - Otherwise, if slot_free: out_valid←0.
  - Otherwise: hold all outputs.
- Squash FSM, states RUN / SQUASH:
  - RUN→SQUASH when a taken branch/JMP is loaded.
  - SQUASH: the next accepted instruction is consumed (in_ready as normal) but loaded as a bubble (out_valid=0), then →RUN.
  - Hazard cycles do not consume the squash.
- Reset:
  - out_valid, brTaken, illegal_op, all enables, EXE_CMD, valuein*, st_data, br_target, dest, src*_forw = 0.
  - state=RUN.

## Timing
- Latency is 1 cycle, input accept to out_valid.
- Throughput is 1 instruction/cycle when out_ready=1.
- Outputs are stable while out_valid && !out_ready.
- brTaken/br_target appear in the cycle after acceptance, qualified by out_valid.
- source1 and src2_reg_file are combinational from instruction, same cycle.
- Flush and hazard in the same cycle: flush wins.
- Flush while out_valid && !out_ready: the instruction is dropped.
- Reset asserted mid-stall returns to RUN with empty output.

## Configuration
- ID_BRANCH_SQUASH_EN defined: the SQUASH state is implemented as above (no delay slot).
- Undefined: no FSM; the instruction following a taken branch executes normally (one architectural delay slot).

## Test plan
- ADD (op 1, rs 2, rt 3, rd 4), registerval1=5, registerval2=7, out_ready=1 → next cycle:
  - out_valid=1, EXE_CMD=1, valuein1=5, valuein2=7, dest=4, writeback=1, src2_forw=3.
- LD with imm=16'hFFFC → valuein2=32'hFFFFFFFC, memory_read=1, writeback=1, src2_forw=0.
  - Repeat with DATA_W=16: valuein2=16'hFFFC.
- BNE, registerval1=3, registerval2=4, pc_in=0x100, imm=2:
  - brTaken=1, br_target=0x108.
  - Following ADD: out_valid=0 with macro, out_valid=1 without.
- out_ready=0 for 3 cycles with a valid LD loaded:
  - in_ready=0, outputs unchanged.
  - out_ready=1 → next instruction loads the next cycle.
- hazard_detected_in=1 for one cycle → in_ready=0, bubble (out_valid=0); the same instruction is accepted the next cycle. flush together with hazard → out_valid=0, state RUN.
- Opcode 50 → illegal_op=1, all enables 0. Async reset asserted mid-sequence → all outputs 0 immediately.
